// File: rtl/mem_cmd_pkg.sv
// mem_cmd_pkg: opcodes, reply bytes and FSM states shared by the command engine
package mem_cmd_pkg;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_FILL  = 8'h03;
  localparam logic [7:0] OP_BOOT  = 8'h04;
  localparam logic [7:0] OP_PING  = 8'h05;
  localparam logic [7:0] RSP_ACK  = 8'hAA;
  localparam logic [7:0] RSP_ERR  = 8'hEE;
  localparam logic [7:0] RSP_PING = 8'h55;
  localparam logic [7:0] BOOT_KEY = 8'h5A;
  typedef enum logic [3:0] {
    IDLE, GET_SEL, GET_ADDR, GET_LEN, GET_DATA, WRITE,
    RD_ISSUE, RD_LATCH, TX_LOAD, TX_WAIT, RESP
  } state_t;
endpackage

// File: rtl/word_shifter.sv
// word_shifter: MSB-first byte <-> word shift register with a wrapping byte counter
module word_shifter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              shift_in,
  input  logic              shift_out,
  input  logic [7:0]        rx_byte,
  input  logic [DATA_W-1:0] load_word,
  output logic [DATA_W-1:0] word_next,
  output logic [7:0]        tx_byte,
  output logic              done
);
  localparam int W  = DATA_W / 8;
  localparam int CW = $clog2(W + 1);
  logic [DATA_W-1:0] word;
  logic [CW-1:0]     cnt;
  // done marks the byte currently being shifted as the last of its word
  assign word_next = DATA_W'({word, rx_byte});
  assign tx_byte   = word[DATA_W-1 -: 8];
  assign done      = cnt == CW'(W - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word <= '0;
      cnt  <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      word <= load_word;
      cnt  <= '0;
    end else if (shift_in || shift_out) begin
      word <= shift_in ? word_next : DATA_W'({word, 8'h00});
      cnt  <= done ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mem_cmd_engine.sv
// mem_cmd_engine: UART byte-stream command parser driving burst read/write/fill on banked BRAM
// Optional RX_TIMEOUT_EN aborts a partial frame after TIMEOUT_CYC idle cycles.
module mem_cmd_engine
  import mem_cmd_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int NUM_BLOCKS  = 16,
  parameter int SEL_W       = $clog2(NUM_BLOCKS),
  parameter int TIMEOUT_CYC = 1_200_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_en,
  output logic [7:0]        tx_data,
  output logic [SEL_W-1:0]  mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              boot,
  output logic              busy,
  output logic              err,
  output logic [2:0]        leds
);
  localparam int AB = (ADDR_W + 7) / 8;
  state_t            state;
  logic [7:0]        op, len, rsp;
  logic [SEL_W-1:0]  sel;
  logic [ADDR_W-1:0] addr;
  logic [2:0]        acnt;
  logic              bad, wlast;
  logic [DATA_W-1:0] sh_next;
  logic [7:0]        sh_byte;
  logic              sh_done;
  assign mem_sel  = sel;
  assign mem_addr = addr;
  assign busy     = state != IDLE;
  assign leds     = {err, busy, boot};
  word_shifter #(.DATA_W(DATA_W)) u_shift (
    .clk(clk),
    .reset(reset),
    .clear(state == IDLE),
    .load(state == RD_LATCH),
    .shift_in(rx_valid && state == GET_DATA && op != OP_BOOT),
    .shift_out(state == TX_LOAD && !tx_busy),
    .rx_byte(rx_data),
    .load_word(mem_rdata),
    .word_next(sh_next),
    .tx_byte(sh_byte),
    .done(sh_done)
  );
`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tcnt;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op        <= '0;
      len       <= '0;
      rsp       <= '0;
      sel       <= '0;
      addr      <= '0;
      acnt      <= '0;
      bad       <= 1'b0;
      wlast     <= 1'b0;
      tx_en     <= 1'b0;
      tx_data   <= '0;
      mem_wdata <= '0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      boot      <= 1'b0;
      err       <= 1'b0;
`ifdef RX_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      tx_en     <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_wr_en <= 1'b0;
      if (rx_valid && state inside {WRITE, RD_ISSUE, RD_LATCH, TX_LOAD, TX_WAIT}) err <= 1'b1;
      case (state)
        IDLE: if (rx_valid) begin
          op  <= rx_data;
          bad <= 1'b0;
          if (rx_data inside {OP_WRITE, OP_READ, OP_FILL}) state <= GET_SEL;
          else if (rx_data == OP_BOOT) state <= GET_DATA;
          else begin
            rsp   <= rx_data == OP_PING ? RSP_PING : RSP_ERR;
            err   <= err | (rx_data != OP_PING);
            state <= RESP;
          end
        end
        GET_SEL: if (rx_valid) begin
          sel   <= rx_data[SEL_W-1:0];
          bad   <= int'(rx_data) >= NUM_BLOCKS;
          acnt  <= '0;
          state <= GET_ADDR;
        end
        GET_ADDR: if (rx_valid) begin
          addr <= ADDR_W'({addr, rx_data});
          acnt <= acnt + 3'd1;
          if (acnt == 3'(AB - 1)) state <= GET_LEN;
        end
        GET_LEN: if (rx_valid) begin
          len <= rx_data;
          if (op != OP_READ) state <= GET_DATA;
          else if (bad) begin
            rsp   <= RSP_ERR;
            err   <= 1'b1;
            state <= RESP;
          end else begin
            mem_rd_en <= 1'b1;
            state     <= RD_ISSUE;
          end
        end
        GET_DATA: if (rx_valid) begin
          if (op == OP_BOOT) begin
            boot  <= boot | (rx_data == BOOT_KEY);
            err   <= err | (rx_data != BOOT_KEY);
            rsp   <= RSP_ERR;
            state <= rx_data == BOOT_KEY ? IDLE : RESP;
          end else if (sh_done) begin
            mem_wdata <= sh_next;
            mem_wr_en <= !bad;
            state     <= WRITE;
          end
        end
        // one committed word per cycle; FILL stays here, WRITE goes back for the next word
        WRITE: begin
          addr <= addr + 1'b1;
          len  <= len - 8'd1;
          if (len == 8'd0) begin
            rsp   <= bad ? RSP_ERR : RSP_ACK;
            if (bad) err <= 1'b1;
            state <= RESP;
          end else if (op == OP_FILL) mem_wr_en <= !bad;
          else state <= GET_DATA;
        end
        RD_ISSUE: state <= RD_LATCH;
        RD_LATCH: state <= TX_LOAD;
        TX_LOAD: if (!tx_busy) begin
          tx_data <= sh_byte;
          tx_en   <= 1'b1;
          wlast   <= sh_done;
          state   <= TX_WAIT;
        end
        TX_WAIT: begin
          if (!wlast) state <= TX_LOAD;
          else if (len == 8'd0) state <= IDLE;
          else begin
            addr      <= addr + 1'b1;
            len       <= len - 8'd1;
            mem_rd_en <= 1'b1;
            state     <= RD_ISSUE;
          end
        end
        RESP: if (!tx_busy) begin
          tx_data <= rsp;
          tx_en   <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
`ifdef RX_TIMEOUT_EN
      if (rx_valid || !(state inside {GET_SEL, GET_ADDR, GET_LEN, GET_DATA})) tcnt <= '0;
      else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
        tcnt  <= '0;
        rsp   <= RSP_ERR;
        err   <= 1'b1;
        state <= RESP;
      end else tcnt <= tcnt + 1'b1;
`endif
    end
  end
endmodule

// File: tb/tb_mem_cmd_engine.sv
// tb_mem_cmd_engine: directed vector table plus hand sequences for burst, fill, select, boot and reset corners
module tb_mem_cmd_engine;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_busy = 1'b0;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic [3:0]  mem_sel;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_rd_en, mem_wr_en;
  logic [15:0] mem_rdata = 16'h0000;
  logic        boot, busy, err;
  logic [2:0]  leds;

  mem_cmd_engine #(.DATA_W(16), .ADDR_W(8), .NUM_BLOCKS(16), .TIMEOUT_CYC(100)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_en(tx_en), .tx_data(tx_data), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_rdata(mem_rdata),
    .boot(boot), .busy(busy), .err(err), .leds(leds)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [16][256] = '{default: '0};
  int wr_cnt = 0;
  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_sel][mem_addr] <= mem_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_rd_en) mem_rdata <= mem[mem_sel][mem_addr];
  end

  logic [7:0] txq[$];
  int bcnt = 0;
  int viol = 0;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (tx_en && (tx_busy || prev_en)) viol++;
    prev_en = tx_en;
    if (tx_en) begin
      txq.push_back(tx_data);
      bcnt = 4;
    end else if (bcnt > 0) bcnt--;
    tx_busy = bcnt > 0;
  end

  int total = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_tx(input int target);
    int t = 0;
    while (txq.size() < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (30) @(negedge clk);
  endtask

  task automatic run_vec(input string nm, input logic [63:0] cmd, input int n,
                         input logic [31:0] rsp, input int nr);
    int b = txq.size();
    for (int k = 0; k < n; k++) send(cmd[8*(n-1-k) +: 8]);
    wait_tx(b + nr);
    chk({nm, " tx count"}, txq.size() - b, nr);
    for (int j = 0; j < nr && b + j < txq.size(); j++)
      chk($sformatf("%s byte%0d", nm, j), {24'h0, txq[b+j]}, {24'h0, rsp[8*(nr-1-j) +: 8]});
  endtask

  typedef struct {
    logic [63:0] cmd;
    int          n;
    logic [31:0] rsp;
    int          nr;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b;
    tbl[0] = '{64'h05, 1, 32'h55, 1};
    tbl[1] = '{64'h01031001BEEFCAFE, 8, 32'hAA, 1};
    tbl[2] = '{64'h02031001, 4, 32'hBEEFCAFE, 4};
    tbl[3] = '{64'h0100FF0111112222, 8, 32'hAA, 1};
    tbl[4] = '{64'h0200FF01, 4, 32'h11112222, 4};
    tbl[5] = '{64'h02010000, 4, 32'h0000, 2};
    tbl[6] = '{64'h05, 1, 32'h55, 1};

    repeat (3) @(negedge clk);
    chk("reset outputs", {31'h0, |{tx_en, tx_data, mem_sel, mem_addr, mem_wdata, mem_rd_en, mem_wr_en}}, 0);
    chk("reset flags", {26'h0, boot, busy, err, leds}, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].n, tbl[i].rsp, tbl[i].nr);
    chk("mem b3 0x10", mem[3][8'h10], 16'hBEEF);
    chk("mem b3 0x11", mem[3][8'h11], 16'hCAFE);
    chk("wrap b0 0xFF", mem[0][8'hFF], 16'h1111);
    chk("wrap b0 0x00", mem[0][8'h00], 16'h2222);
    chk("wrap b1 0x00", mem[1][8'h00], 16'h0000);
    chk("err clean", err, 0);
    chk("busy idle", busy, 0);

    b = wr_cnt;
    run_vec("fill", 64'h030200FF1234, 6, 32'hAA, 1);
    chk("fill wr pulses", wr_cnt - b, 256);
    chk("fill b2 0x00", mem[2][8'h00], 16'h1234);
    chk("fill b2 0xFF", mem[2][8'hFF], 16'h1234);
    run_vec("fill read", 64'h02028000, 4, 32'h1234, 2);

    b = wr_cnt;
    run_vec("bad sel", 64'h01100000AABB, 6, 32'hEE, 1);
    chk("bad sel wr pulses", wr_cnt - b, 0);
    chk("bad sel err", err, 1);
    run_vec("ping after bad", 64'h05, 1, 32'h55, 1);
    run_vec("bad op", 64'h07, 1, 32'hEE, 1);

    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    chk("err cleared", err, 0);
    run_vec("boot bad key", 64'h0400, 2, 32'hEE, 1);
    chk("boot stays 0", boot, 0);
    run_vec("boot key", 64'h045A, 2, 32'h0, 0);
    chk("boot set", boot, 1);
    chk("leds", leds, 3'b101);

    send(8'h02); send(8'h03); send(8'h10);
    chk("busy mid frame", busy, 1);
    send(8'hFF);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    b = txq.size();
    repeat (60) @(negedge clk);
    chk("abort no tx", txq.size() - b, 0);
    chk("abort idle", {busy, boot}, 2'b00);
    chk("abort mem kept", mem[3][8'h10], 16'hBEEF);

`ifdef RX_TIMEOUT_EN
    b = txq.size();
    send(8'h01);
    repeat (60) @(negedge clk);
    chk("timeout early", txq.size() - b, 0);
    wait_tx(b + 1);
    chk("timeout tx count", txq.size() - b, 1);
    if (txq.size() > b) chk("timeout reply", {24'h0, txq[b]}, 32'hEE);
    chk("timeout err", err, 1);
    run_vec("ping after timeout", 64'h05, 1, 32'h55, 1);
`endif

    chk("tx pacing", viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
